// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the ID-stage ALU decoder and its ID/EX register:
//   - ALU op codes (low nibble of ALUcontrol) and the subtract flag (bit 4)
//   - RV32I major opcode values
//   - funct7 patterns that distinguish ADD/SUB and SRL/SRA
//   - the packed ID/EX control record and its bubble value
//   - a helper that maps funct3 onto the shared R-type / I-ALU op encoding
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

    // ALU op codes, carried in ALUcontrol[3:0]
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_AND  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_SLL  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SRA  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;

    // ALUcontrol[4]: invert B and inject carry-in 1 (subtract / compare)
    localparam logic [4:0] ALU_SUB_BIT = 5'b10000;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // funct7 patterns: base encoding and the SUB/SRA alternate
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // Control portion of the ID/EX register (the immediate is kept separately
    // because its width follows the XLEN parameter of the top module).
    typedef struct packed {
        logic [4:0] alu_control;
        logic       alu_src_b;
        logic       branch;
        logic [2:0] funct3;
        logic       valid;
        logic       illegal;
    } id_ex_ctrl_t;

    // A bubble is all zeros: ADD with no side effects and valid = 0
    localparam id_ex_ctrl_t ID_EX_CTRL_BUBBLE = '0;

    // funct3 -> ALUcontrol for the register/immediate ALU groups.
    // SLT/SLTU are compares, so they carry the subtract flag.
    function automatic logic [4:0] alu_from_funct3(input logic [2:0] f3);
        logic [4:0] op;
        case (f3)
            3'b000:  op = {1'b0, ALU_ADD};
            3'b001:  op = {1'b0, ALU_SLL};
            3'b010:  op = ALU_SUB_BIT | {1'b0, ALU_SLT};
            3'b011:  op = ALU_SUB_BIT | {1'b0, ALU_SLTU};
            3'b100:  op = {1'b0, ALU_XOR};
            3'b101:  op = {1'b0, ALU_SRL};
            3'b110:  op = {1'b0, ALU_OR};
            default: op = {1'b0, ALU_AND};
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_ex_alu_decode_imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen
// Combinational immediate generator for RV32I. The immediate format
// (I, S, B, U, J, or zero-extended shamt for immediate shifts) is chosen by
// the major opcode; opcodes without an immediate produce 0.
// Ports:
//   instr  in   32    instruction word from IF/ID
//   imm    out  XLEN  sign-extended immediate
// ---------------------------------------------------------------------------
module imm_gen
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm32;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // Build the 32-bit immediate for the format implied by the opcode.
    always_comb begin
        imm32 = '0;
        case (opcode)
            OPC_LOAD, OPC_JALR:
                imm32 = {{20{instr[31]}}, instr[31:20]};
            OPC_OP_IMM: begin
                // Immediate shifts use only the 5-bit shamt, zero-extended
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    imm32 = {27'b0, instr[24:20]};
                else
                    imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_STORE:
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                         instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm32 = {instr[31:12], 12'b0};
            OPC_JAL:
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                         instr[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    // Widen to the datapath width, replicating the sign bit
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_ex_alu_decode.sv
// ---------------------------------------------------------------------------
// id_ex_alu_decode
// ID-stage ALU decoder plus the ID/EX pipeline register. Decodes an RV32I
// instruction into the 5-bit ALUcontrol word (bit4 = subtract, [3:0] = op),
// the B-operand select and the immediate, then registers them with
// stall (hold) and flush (bubble) control. Priority: reset > flush > stall.
//
// Build option: ILLEGAL_DETECT_EN
//   defined   - undecodable instructions load with valid = 1, illegal = 1;
//               funct7 / shamt upper bits are fully checked.
//   undefined - illegal output is tied to 0, undecodable instructions load
//               as a bubble, and funct7[5] alone selects SUB/SRA.
//
// Ports:
//   clk               in   1     rising-edge clock
//   reset             in   1     synchronous, active-high reset
//   IF_ID_instr       in   32    instruction from IF/ID
//   IF_ID_valid       in   1     IF/ID holds a real instruction
//   stall             in   1     hold ID/EX contents
//   flush             in   1     load a bubble into ID/EX
//   ID_EX_ALUcontrol  out  5     ALU control word
//   ID_EX_alu_src_b   out  1     0 = rs2, 1 = immediate
//   ID_EX_imm         out  XLEN  sign-extended immediate
//   ID_EX_branch      out  1     conditional branch
//   ID_EX_funct3      out  3     funct3 for branch resolution
//   ID_EX_valid       out  1     ID/EX holds a real instruction
//   ID_EX_illegal     out  1     undecodable instruction
// ---------------------------------------------------------------------------
module id_ex_alu_decode
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     IF_ID_instr,
    input  logic            IF_ID_valid,
    input  logic            stall,
    input  logic            flush,
    output logic [4:0]      ID_EX_ALUcontrol,
    output logic            ID_EX_alu_src_b,
    output logic [XLEN-1:0] ID_EX_imm,
    output logic            ID_EX_branch,
    output logic [2:0]      ID_EX_funct3,
    output logic            ID_EX_valid,
    output logic            ID_EX_illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
`ifdef ILLEGAL_DETECT_EN
    logic [6:0]      funct7;
`endif
    logic [XLEN-1:0] imm_dec;
    logic [4:0]      dec_alu;
    logic            dec_src_b;
    logic            dec_branch;
    logic            dec_bad;
    id_ex_ctrl_t     next_ctrl;
    logic [XLEN-1:0] next_imm;
    id_ex_ctrl_t     ctrl_q;
    logic [XLEN-1:0] imm_q;

    assign opcode = IF_ID_instr[6:0];
    assign funct3 = IF_ID_instr[14:12];
`ifdef ILLEGAL_DETECT_EN
    assign funct7 = IF_ID_instr[31:25];
`endif

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr (IF_ID_instr),
        .imm   (imm_dec)
    );

    // Opcode/funct decode. dec_bad flags anything that cannot be decoded,
    // including unknown opcodes; what happens to such instructions is
    // decided when the next register value is assembled.
    always_comb begin
        dec_alu    = {1'b0, ALU_ADD};
        dec_src_b  = 1'b0;
        dec_branch = 1'b0;
        dec_bad    = 1'b0;
        case (opcode)
            OPC_OP: begin
`ifdef ILLEGAL_DETECT_EN
                if (funct7 == FUNCT7_BASE)
                    dec_alu = alu_from_funct3(funct3);
                else if (funct7 == FUNCT7_ALT && funct3 == 3'b000)
                    dec_alu = ALU_SUB_BIT | {1'b0, ALU_ADD};
                else if (funct7 == FUNCT7_ALT && funct3 == 3'b101)
                    dec_alu = {1'b0, ALU_SRA};
                else
                    dec_bad = 1'b1;
`else
                if (IF_ID_instr[30] && funct3 == 3'b000)
                    dec_alu = ALU_SUB_BIT | {1'b0, ALU_ADD};
                else if (IF_ID_instr[30] && funct3 == 3'b101)
                    dec_alu = {1'b0, ALU_SRA};
                else
                    dec_alu = alu_from_funct3(funct3);
`endif
            end
            OPC_OP_IMM: begin
                dec_src_b = 1'b1;
                if (funct3 == 3'b001) begin
                    dec_alu = {1'b0, ALU_SLL};
`ifdef ILLEGAL_DETECT_EN
                    if (funct7 != FUNCT7_BASE)
                        dec_bad = 1'b1;
`endif
                end else if (funct3 == 3'b101) begin
`ifdef ILLEGAL_DETECT_EN
                    if (funct7 == FUNCT7_BASE)
                        dec_alu = {1'b0, ALU_SRL};
                    else if (funct7 == FUNCT7_ALT)
                        dec_alu = {1'b0, ALU_SRA};
                    else
                        dec_bad = 1'b1;
`else
                    dec_alu = IF_ID_instr[30] ? {1'b0, ALU_SRA} : {1'b0, ALU_SRL};
`endif
                end else begin
                    // ADDI never subtracts, so funct3 alone decides
                    dec_alu = alu_from_funct3(funct3);
                end
            end
            OPC_LOAD, OPC_STORE, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                dec_src_b = 1'b1;
            end
            OPC_BRANCH: begin
                // BEQ/BNE test the difference for zero, BLT/BGE reuse SLT,
                // BLTU/BGEU reuse SLTU; funct3 = 2/3 has no branch defined.
                dec_branch = 1'b1;
                case (funct3[2:1])
                    2'b00:   dec_alu = ALU_SUB_BIT | {1'b0, ALU_ADD};
                    2'b10:   dec_alu = ALU_SUB_BIT | {1'b0, ALU_SLT};
                    2'b11:   dec_alu = ALU_SUB_BIT | {1'b0, ALU_SLTU};
                    default: dec_bad = 1'b1;
                endcase
            end
            default: begin
                dec_bad = 1'b1;
            end
        endcase
    end

    // Assemble the value the ID/EX register would load this cycle. A missing
    // instruction is a bubble; an undecodable one either becomes a bubble or
    // a valid-but-illegal entry with all ALU side effects cleared.
    always_comb begin
        next_ctrl = ID_EX_CTRL_BUBBLE;
        next_imm  = '0;
        if (IF_ID_valid && !dec_bad) begin
            next_ctrl.alu_control = dec_alu;
            next_ctrl.alu_src_b   = dec_src_b;
            next_ctrl.branch      = dec_branch;
            next_ctrl.funct3      = funct3;
            next_ctrl.valid       = 1'b1;
            next_imm              = imm_dec;
        end
`ifdef ILLEGAL_DETECT_EN
        else if (IF_ID_valid) begin
            next_ctrl.funct3  = funct3;
            next_ctrl.valid   = 1'b1;
            next_ctrl.illegal = 1'b1;
        end
`endif
    end

    // ID/EX register: reset and flush both insert a bubble, stall holds
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= ID_EX_CTRL_BUBBLE;
            imm_q  <= '0;
        end else if (flush) begin
            ctrl_q <= ID_EX_CTRL_BUBBLE;
            imm_q  <= '0;
        end else if (!stall) begin
            ctrl_q <= next_ctrl;
            imm_q  <= next_imm;
        end
    end

    assign ID_EX_ALUcontrol = ctrl_q.alu_control;
    assign ID_EX_alu_src_b  = ctrl_q.alu_src_b;
    assign ID_EX_imm        = imm_q;
    assign ID_EX_branch     = ctrl_q.branch;
    assign ID_EX_funct3     = ctrl_q.funct3;
    assign ID_EX_valid      = ctrl_q.valid;
    assign ID_EX_illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_alu_decode.sv
// ---------------------------------------------------------------------------
// tb_id_ex_alu_decode
// Self-checking bench for id_ex_alu_decode: directed instructions followed
// by randomized instructions and control, compared cycle by cycle against a
// reference model written directly from the RV32I field definitions.
// Honours ILLEGAL_DETECT_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_id_ex_alu_decode;

    typedef struct packed {
        logic [4:0]  alu;
        logic        src_b;
        logic [31:0] imm;
        logic        branch;
        logic [2:0]  f3;
        logic        valid;
        logic        illegal;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] IF_ID_instr;
    logic        IF_ID_valid;
    logic        stall;
    logic        flush;
    logic [4:0]  ID_EX_ALUcontrol;
    logic        ID_EX_alu_src_b;
    logic [31:0] ID_EX_imm;
    logic        ID_EX_branch;
    logic [2:0]  ID_EX_funct3;
    logic        ID_EX_valid;
    logic        ID_EX_illegal;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q    = '0;

    id_ex_alu_decode #(
        .XLEN (32)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .IF_ID_instr      (IF_ID_instr),
        .IF_ID_valid      (IF_ID_valid),
        .stall            (stall),
        .flush            (flush),
        .ID_EX_ALUcontrol (ID_EX_ALUcontrol),
        .ID_EX_alu_src_b  (ID_EX_alu_src_b),
        .ID_EX_imm        (ID_EX_imm),
        .ID_EX_branch     (ID_EX_branch),
        .ID_EX_funct3     (ID_EX_funct3),
        .ID_EX_valid      (ID_EX_valid),
        .ID_EX_illegal    (ID_EX_illegal)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALUcontrol for funct3 in the register/immediate ALU groups
    function automatic logic [4:0] op_for_f3(input logic [2:0] f3);
        logic [4:0] tbl [0:7];
        tbl = '{5'h00, 5'h04, 5'h17, 5'h18, 5'h03, 5'h05, 5'h02, 5'h01};
        return tbl[f3];
    endfunction

    // Reference decode: what the ID/EX register should hold after loading
    // instr with the given valid flag.
    function automatic exp_t ref_decode(input logic [31:0] instr, input logic v);
        exp_t        e;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] i_imm, s_imm, b_imm, j_imm, u_imm;
        logic        bad;
        e   = '0;
        bad = 1'b0;
        if (!v) return e;
        opc   = instr[6:0];
        f3    = instr[14:12];
        f7    = instr[31:25];
        i_imm = instr[31] ? ((instr >> 20) | 32'hFFFFF000) : (instr >> 20);
        s_imm = (i_imm & ~32'h1F) | ((instr >> 7) & 32'h1F);
        b_imm = (instr[31] ? 32'hFFFFF000 : 32'h0) + 32'(instr[7]) * 2048
              + 32'(instr[30:25]) * 32 + 32'(instr[11:8]) * 2;
        j_imm = (instr[31] ? 32'hFFF00000 : 32'h0) + 32'(instr[19:12]) * 4096
              + 32'(instr[20]) * 2048 + 32'(instr[30:21]) * 2;
        u_imm = instr & 32'hFFFFF000;
        e.f3    = f3;
        e.valid = 1'b1;
        case (opc)
            7'h33: begin
`ifdef ILLEGAL_DETECT_EN
                if (f7 == 7'h00) e.alu = op_for_f3(f3);
                else if (f7 == 7'h20 && f3 == 3'd0) e.alu = 5'h10;
                else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 5'h06;
                else bad = 1'b1;
`else
                if (f7[5] && f3 == 3'd0) e.alu = 5'h10;
                else if (f7[5] && f3 == 3'd5) e.alu = 5'h06;
                else e.alu = op_for_f3(f3);
`endif
            end
            7'h13: begin
                e.src_b = 1'b1;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.imm = (instr >> 20) & 32'h1F;
`ifdef ILLEGAL_DETECT_EN
                    if (f7 == 7'h00) e.alu = (f3 == 3'd1) ? 5'h04 : 5'h05;
                    else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 5'h06;
                    else bad = 1'b1;
`else
                    e.alu = (f3 == 3'd1) ? 5'h04 : (f7[5] ? 5'h06 : 5'h05);
`endif
                end else begin
                    e.alu = op_for_f3(f3);
                    e.imm = i_imm;
                end
            end
            7'h03, 7'h67: begin e.src_b = 1'b1; e.imm = i_imm; end
            7'h23:        begin e.src_b = 1'b1; e.imm = s_imm; end
            7'h37, 7'h17: begin e.src_b = 1'b1; e.imm = u_imm; end
            7'h6F:        begin e.src_b = 1'b1; e.imm = j_imm; end
            7'h63: begin
                e.branch = 1'b1;
                e.imm    = b_imm;
                if (f3 == 3'd0 || f3 == 3'd1) e.alu = 5'h10;
                else if (f3 == 3'd4 || f3 == 3'd5) e.alu = 5'h17;
                else if (f3 == 3'd6 || f3 == 3'd7) e.alu = 5'h18;
                else bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            e = '0;
`ifdef ILLEGAL_DETECT_EN
            e.valid   = 1'b1;
            e.illegal = 1'b1;
            e.f3      = f3;
`endif
        end
        return e;
    endfunction

    // One comparison: counts it and reports any difference
    task automatic checkValue(input string tag, input logic [31:0] obs,
                              input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Compare every output against the model's register state
    task automatic checkOutput(input string tag);
        checkValue({tag, ".alu"},     32'(ID_EX_ALUcontrol), 32'(exp_q.alu));
        checkValue({tag, ".src_b"},   32'(ID_EX_alu_src_b),  32'(exp_q.src_b));
        checkValue({tag, ".imm"},     ID_EX_imm,             exp_q.imm);
        checkValue({tag, ".branch"},  32'(ID_EX_branch),     32'(exp_q.branch));
        checkValue({tag, ".funct3"},  32'(ID_EX_funct3),     32'(exp_q.f3));
        checkValue({tag, ".valid"},   32'(ID_EX_valid),      32'(exp_q.valid));
        checkValue({tag, ".illegal"}, 32'(ID_EX_illegal),    32'(exp_q.illegal));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then check
    task automatic applyStimulus(input logic [31:0] instr, input logic v,
                                 input logic st, input logic fl,
                                 input logic rst, input string tag);
        @(negedge clk);
        IF_ID_instr = instr;
        IF_ID_valid = v;
        stall       = st;
        flush       = fl;
        reset       = rst;
        @(posedge clk);
        if (rst)      exp_q = '0;
        else if (fl)  exp_q = '0;
        else if (!st) exp_q = ref_decode(instr, v);
        #1;
        checkOutput(tag);
    endtask

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_SRAI = 32'h40335293;
    localparam logic [31:0] I_LW   = 32'hFFC12083;
    localparam logic [31:0] I_BLT  = 32'h0020C463;

    initial begin
        logic [6:0]  opc_tab [0:9];
        logic [31:0] r;
        logic [6:0]  opc;
        opc_tab = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                    7'h37, 7'h17, 7'h6F, 7'h67, 7'h00};
        reset       = 1'b1;
        IF_ID_instr = '0;
        IF_ID_valid = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;

        applyStimulus(I_ADD, 1'b1, 1'b0, 1'b0, 1'b1, "reset");
        checkValue("reset_valid", 32'(ID_EX_valid), 32'd0);

        applyStimulus(I_ADD, 1'b1, 1'b0, 1'b0, 1'b0, "add");
        checkValue("add_alu",   32'(ID_EX_ALUcontrol), 32'h00);
        checkValue("add_valid", 32'(ID_EX_valid),      32'd1);

        applyStimulus(I_SUB, 1'b1, 1'b0, 1'b0, 1'b0, "sub");
        checkValue("sub_alu", 32'(ID_EX_ALUcontrol), 32'h10);

        applyStimulus(I_SRAI, 1'b1, 1'b0, 1'b0, 1'b0, "srai");
        checkValue("srai_alu", 32'(ID_EX_ALUcontrol), 32'h06);
        checkValue("srai_imm", ID_EX_imm,             32'h00000003);

        applyStimulus(I_LW, 1'b1, 1'b0, 1'b0, 1'b0, "lw");
        checkValue("lw_imm", ID_EX_imm, 32'hFFFFFFFC);

        applyStimulus(I_BLT, 1'b1, 1'b0, 1'b0, 1'b0, "blt");
        checkValue("blt_alu",    32'(ID_EX_ALUcontrol), 32'h17);
        checkValue("blt_imm",    ID_EX_imm,             32'h00000008);
        checkValue("blt_funct3", 32'(ID_EX_funct3),     32'd4);

        applyStimulus(I_ADD, 1'b1, 1'b0, 1'b0, 1'b0, "add2");
        applyStimulus(I_SUB, 1'b1, 1'b1, 1'b0, 1'b0, "stall_hold");
        checkValue("stall_alu", 32'(ID_EX_ALUcontrol), 32'h00);
        checkValue("stall_valid", 32'(ID_EX_valid), 32'd1);
        applyStimulus(I_SUB, 1'b1, 1'b1, 1'b1, 1'b0, "stall_flush");
        checkValue("flush_valid", 32'(ID_EX_valid), 32'd0);

        applyStimulus(32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, "zero_instr");
`ifdef ILLEGAL_DETECT_EN
        checkValue("zero_illegal", 32'(ID_EX_illegal), 32'd1);
`else
        checkValue("zero_valid", 32'(ID_EX_valid), 32'd0);
`endif

        applyStimulus(I_ADD, 1'b0, 1'b0, 1'b0, 1'b0, "not_valid");
        checkValue("nv_valid", 32'(ID_EX_valid), 32'd0);

        applyStimulus(I_SRAI, 1'b1, 1'b0, 1'b0, 1'b0, "pre_reset");
        applyStimulus(I_SUB, 1'b1, 1'b1, 1'b0, 1'b1, "reset_in_stall");
        checkValue("rst_stall_imm", ID_EX_imm, 32'd0);
        applyStimulus(I_SUB, 1'b1, 1'b0, 1'b0, 1'b0, "resume");
        checkValue("resume_alu", 32'(ID_EX_ALUcontrol), 32'h10);

        // Randomized instruction mix with random pipeline control
        for (int n = 0; n < 400; n++) begin
            r   = $urandom;
            opc = opc_tab[$urandom_range(0, 9)];
            if (opc == 7'h00) opc = 7'(r);
            r[6:0] = opc;
            if ((opc == 7'h33 || opc == 7'h13) && $urandom_range(0, 3) != 0)
                r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            applyStimulus(r,
                          $urandom_range(0, 99) < 85,
                          $urandom_range(0, 99) < 20,
                          $urandom_range(0, 99) < 10,
                          $urandom_range(0, 99) < 2,
                          "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
